uart_tx_fifo: RTL and testbench

//  Parametrised RS-232 transmitter with an input FIFO. Serialises queued words

---
 rtl/uart_tx_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Queued RS-232 transmitter: a power-of-two word FIFO feeding a start/data/parity/stop
// serialiser. Frames run back to back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 100,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = AddrW + 1;

  localparam logic [15:0] BaudReload = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LastData   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LastStop   = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]    level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, wr_en, pop;
  logic [DATA_BITS-1:0] head;

  // Serialiser state
  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 baud_last;

  assign full      = (level_q == LevelW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  // A full FIFO refuses writes even if a pop happens in the same cycle.
  assign wr_en     = wr_valid & ~full;
  assign head      = mem_q[rd_ptr_q];
  assign baud_last = (baud_q == 16'd0);

  // Serialiser next state; every bit boundary reloads the baud counter.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) pop = 1'b1;
      end
      StStart: begin
        if (baud_last) begin
          state_d   = StData;
          baud_d    = BaudReload;
          bit_cnt_d = 4'd0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = BaudReload;
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = 4'd0;
            if (PARITY != 0) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StParity: begin
        if (baud_last) begin
          state_d   = StStop;
          baud_d    = BaudReload;
          bit_cnt_d = 4'd0;
          tx_d      = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StStop: begin
        if (baud_last) begin
          if (bit_cnt_q == LastStop) begin
            if (!empty) pop = 1'b1;
            else        state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            baud_d    = BaudReload;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Loading a word starts the next frame immediately, from idle or the last stop cycle.
    if (pop) begin
      state_d = StStart;
      baud_d  = BaudReload;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
      tx_d    = 1'b0;
    end
  end

  // FIFO pointer, level and sticky overflow next state
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !pop)      level_d = level_q + LevelW'(1);
    else if (!wr_en && pop) level_d = level_q - LevelW'(1);
    ovf_d = ovf_q | (wr_valid & full);
  end

  // Register file with synchronous active-low reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= 16'd0;
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign wr_ready   = ~full;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) | ~empty;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations checked every cycle against a frame-level
// model, a serial receiver on the fast instance, and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int NI = 3;
  localparam int DIV [NI] = '{100, 100, 2};
  localparam int DB  [NI] = '{8, 7, 5};
  localparam int PAR [NI] = '{0, 2, 1};
  localparam int STB [NI] = '{1, 2, 2};
  localparam int DEP [NI] = '{16, 4, 4};
  localparam int NB2 = 1 + DB[2] + ((PAR[2] != 0) ? 1 : 0) + STB[2];

  logic       clk, rst_n;
  logic [8:0] wr_data  [NI];
  logic       wr_valid [NI];
  logic       wr_ready_w [NI];
  logic       tx_w [NI];
  logic       busy_w [NI];
  logic       ovf_w [NI];
  logic [8:0] level_w [NI];
  logic [4:0] lvl0;
  logic [2:0] lvl1, lvl2;

  assign level_w[0] = 9'(lvl0);
  assign level_w[1] = 9'(lvl1);
  assign level_w[2] = 9'(lvl2);

  uart_tx_fifo #(.CLK_DIV(DIV[0]), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(STB[0]),
                 .FIFO_DEPTH(DEP[0])) u0 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data[0][7:0]), .wr_valid(wr_valid[0]),
    .wr_ready(wr_ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl0),
    .overflow(ovf_w[0]));

  uart_tx_fifo #(.CLK_DIV(DIV[1]), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(STB[1]),
                 .FIFO_DEPTH(DEP[1])) u1 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data[1][6:0]), .wr_valid(wr_valid[1]),
    .wr_ready(wr_ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl1),
    .overflow(ovf_w[1]));

  uart_tx_fifo #(.CLK_DIV(DIV[2]), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(STB[2]),
                 .FIFO_DEPTH(DEP[2])) u2 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data[2][4:0]), .wr_valid(wr_valid[2]),
    .wr_ready(wr_ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl2),
    .overflow(ovf_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit en = 1'b0;
  int r_cnt = 0;

  // Model state: a word queue plus the frame currently on the line.
  int          m_cnt [NI], m_head [NI], m_pos [NI], m_len [NI], m_acc [NI];
  bit          m_active [NI], m_ovf [NI];
  logic [15:0] m_bits [NI];
  int          m_mem [NI][16];
  int          rxq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Serial image of one word, first bit on the line at index 0.
  function automatic logic [15:0] frame_of(input int k, input int w, output int nb);
    logic [15:0] f;
    int ones;
    f = '0;
    nb = 1;
    ones = 0;
    for (int i = 0; i < DB[k]; i++) begin
      f[nb] = w[i];
      ones += w[i];
      nb++;
    end
    if (PAR[k] != 0) begin
      f[nb] = (PAR[k] == 2) ? ones[0] : ~ones[0];
      nb++;
    end
    for (int s = 0; s < STB[k]; s++) begin
      f[nb] = 1'b1;
      nb++;
    end
    return f;
  endfunction

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (rst_n !== 1'b1) begin
        m_cnt[k] = 0; m_head[k] = 0; m_active[k] = 0; m_pos[k] = 0; m_ovf[k] = 0;
        if (k == 2) rxq.delete();
      end else begin
        bit full, pop;
        int w, nb;
        full = (m_cnt[k] == DEP[k]);
        pop  = (m_cnt[k] > 0) && (!m_active[k] || m_pos[k] == m_len[k] - 1);
        if (m_active[k]) begin
          m_pos[k]++;
          if (m_pos[k] == m_len[k]) m_active[k] = 0;
        end
        if (wr_valid[k] && full) m_ovf[k] = 1;
        if (pop) begin
          w = m_mem[k][m_head[k]];
          m_head[k] = (m_head[k] + 1) % DEP[k];
          m_cnt[k]--;
          m_bits[k] = frame_of(k, w, nb);
          m_len[k] = nb * DIV[k];
          m_pos[k] = 0;
          m_active[k] = 1;
        end
        if (wr_valid[k] && !full) begin
          w = int'(wr_data[k]) & ((1 << DB[k]) - 1);
          m_mem[k][(m_head[k] + m_cnt[k]) % DEP[k]] = w;
          m_cnt[k]++;
          m_acc[k]++;
          if (k == 2) rxq.push_back(w);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every output of every instance.
  initial begin
    forever begin
      @(negedge clk);
      if (en) begin
        for (int k = 0; k < NI; k++) begin
          logic [12:0] act, exp;
          logic exp_tx;
          exp_tx = m_active[k] ? m_bits[k][m_pos[k] / DIV[k]] : 1'b1;
          act = {tx_w[k], busy_w[k], wr_ready_w[k], ovf_w[k], level_w[k]};
          exp = {exp_tx, (m_active[k] || m_cnt[k] != 0), (m_cnt[k] < DEP[k]), m_ovf[k],
                 9'(m_cnt[k])};
          check($sformatf("cycle_u%0d", k), act, exp);
        end
      end
    end
  end

  // Receiver on u2: sample each bit in its last cycle, compare whole frames.
  initial begin
    bit r_on;
    int r_pos, nb, w;
    logic [15:0] r_f, exp_f;
    r_on = 0;
    r_pos = 0;
    r_f = '0;
    forever begin
      @(negedge clk);
      if (!en || rst_n !== 1'b1) begin
        r_on = 0;
      end else begin
        if (!r_on && tx_w[2] === 1'b0) begin
          r_on = 1;
          r_pos = 0;
          r_f = '0;
        end
        if (r_on) begin
          if (r_pos % DIV[2] == DIV[2] - 1) begin
            r_f[r_pos / DIV[2]] = tx_w[2];
            if (r_pos / DIV[2] == NB2 - 1) begin
              r_on = 0;
              if (rxq.size() == 0) begin
                n_chk++;
                $display("FAIL rx_unexpected: got frame 0x%0h, expected none", r_f);
              end else begin
                w = rxq.pop_front();
                exp_f = frame_of(2, w, nb);
                check("rx_frame", r_f, exp_f);
                r_cnt++;
              end
            end
          end
          r_pos++;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int w);
    wr_valid[k] = 1'b1;
    wr_data[k]  = 9'(w);
    step();
    wr_valid[k] = 1'b0;
  endtask

  task automatic wait_busy_low(input int k, input int budget, input string name,
                               output time t);
    int c;
    c = 0;
    while (busy_w[k] !== 1'b0 && c < budget) begin
      step();
      c++;
    end
    check({name, "_busy_within_budget"}, (c < budget), 1);
    t = $time;
  endtask

  // Send one word to idle instance k; sample frame bit idx mid-bit; time the busy window.
  task automatic probe(input int k, input int w, input int idx, input string name,
                       output logic b, output time dur);
    time t0, t1;
    push(k, w);
    step();
    t0 = $time;
    repeat (idx * DIV[k] + DIV[k] / 2) step();
    b = tx_w[k];
    wait_busy_low(k, 3000, name, t1);
    dur = t1 - t0;
  endtask

  initial begin
    time t_f, t_b, dur;
    logic [9:0] got;
    logic pb;
    int lows, cyc, start;

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      wr_valid[k] = 1'b0;
      wr_data[k]  = '0;
    end
    step();
    en = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    check("rst_tx", tx_w[0], 1);
    check("rst_ready", wr_ready_w[1], 1);
    check("rst_busy", busy_w[2], 0);
    check("rst_level", level_w[0], 0);
    check("rst_ovf", ovf_w[1], 0);
    step();

    // 8N1 single word 0x41
    push(0, 'h41);
    check("t1_level1", level_w[0], 1);
    check("t1_tx_still_idle", tx_w[0], 1);
    step();
    check("t1_tx_start", tx_w[0], 0);
    check("t1_level0", level_w[0], 0);
    t_f = $time;
    repeat (50) step();
    for (int i = 0; i < 10; i++) begin
      got[i] = tx_w[0];
      if (i < 9) repeat (100) step();
    end
    check("t1_bits", got, 10'h282);
    wait_busy_low(0, 2000, "t1", t_b);
    check("t1_busy_ns", t_b - t_f, 10000);
    repeat (5) step();

    // Three back-to-back words
    push(0, 'h55);
    push(0, 'hAA);
    t_f = $time;
    check("t2_tx_start", tx_w[0], 0);
    push(0, 'h00);
    check("t2_level2", level_w[0], 2);
    wait_busy_low(0, 4000, "t2", t_b);
    check("t2_busy_ns", t_b - t_f, 30000);
    repeat (5) step();

    // Parity: 7E2 and 5O2
    probe(1, 'h03, 8, "t3a", pb, dur);
    check("t3_even_03_parity", pb, 0);
    check("t3_7e2_frame_ns", dur, 11000);
    probe(1, 'h07, 8, "t3b", pb, dur);
    check("t3_even_07_parity", pb, 1);
    probe(2, 'h03, 6, "t3c", pb, dur);
    check("t3_odd_03_parity", pb, 1);
    check("t3_5o2_frame_ns", dur, 180);
    probe(2, 'h07, 6, "t3d", pb, dur);
    check("t3_odd_07_parity", pb, 0);
    repeat (5) step();

    // Overflow on a depth-4 FIFO
    t_f = 0;
    for (int i = 0; i < 8; i++) begin
      wr_valid[1] = 1'b1;
      wr_data[1]  = 9'(i + 1);
      step();
      if (i == 1) t_f = $time;
    end
    wr_valid[1] = 1'b0;
    check("t4_ready_low", wr_ready_w[1], 0);
    check("t4_overflow", ovf_w[1], 1);
    check("t4_level4", level_w[1], 4);
    wait_busy_low(1, 7000, "t4", t_b);
    check("t4_five_frames_ns", t_b - t_f, 55000);
    check("t4_overflow_sticky", ovf_w[1], 1);
    repeat (5) step();

    // Reset in the middle of data bit 3
    push(0, 'h5A);
    push(0, 'h3C);
    repeat (450) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_tx_high", tx_w[0], 1);
    check("t5_level0", level_w[0], 0);
    check("t5_ovf0", ovf_w[0], 0);
    check("t5_busy0", busy_w[0], 0);
    check("t5_u1_ovf_cleared", ovf_w[1], 0);
    lows = 0;
    repeat (2000) begin
      step();
      if (tx_w[0] !== 1'b1) lows++;
    end
    check("t5_no_frames_after_reset", lows, 0);

    // Random stream into the fast 5-bit instance
    cyc = 0;
    start = m_acc[2];
    while (m_acc[2] - start < 1000 && cyc < 40000) begin
      wr_valid[2] = ($urandom_range(0, 3) != 0);
      wr_data[2]  = 9'($urandom);
      step();
      cyc++;
    end
    wr_valid[2] = 1'b0;
    check("t6_words_accepted", m_acc[2] - start, 1000);
    check("t6_overflow_seen", ovf_w[2], 1);
    wait_busy_low(2, 500, "t6", t_b);
    repeat (5) step();
    check("t6_rx_count", r_cnt, m_acc[2]);
    check("t6_rx_drained", rxq.size(), 0);

    en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
